// File: rtl/usr_pkg.sv
// Shared definitions for the 8-bit universal shift register and its sequencer.
package usr_pkg;

  // USR mode encoding, shared by the USR and the sequencer that drives it.
  localparam logic [1:0] LOAD_PARALLEL = 2'h0;
  localparam logic [1:0] SHIFT_RIGHT   = 2'h1;
  localparam logic [1:0] SHIFT_LEFT    = 2'h2;
  localparam logic [1:0] NO_CHANGE     = 2'h3;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4
  } seq_state_t;

  // LSB-first frames shift toward bit 0, MSB-first frames toward bit 7.
  function automatic logic [1:0] shift_mode(input logic lsb_first);
    return lsb_first ? SHIFT_RIGHT : SHIFT_LEFT;
  endfunction

endpackage

// File: rtl/usr_shift_sequencer.sv
// Sequencer that loads a byte into the universal shift register and then
// alternates HOLD/SHIFT so each bit sits on the USR serial output for one full
// rising-edge-to-rising-edge window. The USR samples its inputs on the falling
// edge, so the registered mode driven here is always stable when it is used.
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDLE_GAP   = 1
) (
  input  logic                          Clk_In,
  input  logic                          Reset_In,
  input  logic [DATA_WIDTH-1:0]         Tx_Data_In,
  input  logic                          Tx_Valid_In,
  input  logic                          Tx_Lsb_First_In,
  output logic                          Tx_Ready_Out,
  input  logic                          Abort_In,
  output logic [1:0]                    USR_Mode_Out,
  output logic [DATA_WIDTH-1:0]         USR_Parallel_Data_Out,
  output logic                          Serial_Bit_Valid_Out,
  output logic [$clog2(DATA_WIDTH)-1:0] Bit_Index_Out,
  output logic                          Busy_Out,
  output logic                          Frame_Done_Out
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);
  localparam logic [3:0] GAP_LOAD = 4'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);
  localparam bit HAS_GAP = (IDLE_GAP > 0);

  seq_state_t       state;
  logic [IDX_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic             lsb_first;

  // Bit counter counts presented bits in time order; map it to the original
  // data-bit index according to the direction latched at accept.
  function automatic logic [IDX_W-1:0] present_index(input logic lsb,
                                                     input logic [IDX_W-1:0] k);
    return lsb ? k : (LAST_BIT - k);
  endfunction

  // Frame FSM; every output is registered and takes the value for the state entered.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state                 <= ST_IDLE;
      bit_cnt               <= '0;
      gap_cnt               <= '0;
      lsb_first             <= 1'b0;
      USR_Mode_Out          <= NO_CHANGE;
      USR_Parallel_Data_Out <= '0;
      Tx_Ready_Out          <= 1'b1;
      Serial_Bit_Valid_Out  <= 1'b0;
      Bit_Index_Out         <= '0;
      Busy_Out              <= 1'b0;
      Frame_Done_Out        <= 1'b0;
    end else begin
      // Strobes default low; only HOLD entry and frame completion raise them.
      Frame_Done_Out       <= 1'b0;
      Serial_Bit_Valid_Out <= 1'b0;
      if (Abort_In) begin
        // Abort wins over everything, including an accept while idle.
        state         <= ST_IDLE;
        bit_cnt       <= '0;
        gap_cnt       <= '0;
        USR_Mode_Out  <= NO_CHANGE;
        Tx_Ready_Out  <= 1'b1;
        Busy_Out      <= 1'b0;
        Bit_Index_Out <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (Tx_Valid_In && Tx_Ready_Out) begin
              state                 <= ST_LOAD;
              USR_Parallel_Data_Out <= Tx_Data_In;
              lsb_first             <= Tx_Lsb_First_In;
              bit_cnt               <= '0;
              USR_Mode_Out          <= LOAD_PARALLEL;
              Tx_Ready_Out          <= 1'b0;
              Busy_Out              <= 1'b1;
            end
          end
          ST_LOAD: begin
            state                <= ST_HOLD;
            USR_Mode_Out         <= NO_CHANGE;
            Serial_Bit_Valid_Out <= 1'b1;
            Bit_Index_Out        <= present_index(lsb_first, bit_cnt);
          end
          ST_HOLD: begin
            if (bit_cnt == LAST_BIT) begin
              // Last bit presented: the check happens before any increment,
              // so the counter never wraps inside a frame.
              Frame_Done_Out <= 1'b1;
              USR_Mode_Out   <= NO_CHANGE;
              bit_cnt        <= '0;
              if (HAS_GAP) begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LOAD;
              end else begin
                state        <= ST_IDLE;
                Tx_Ready_Out <= 1'b1;
                Busy_Out     <= 1'b0;
              end
            end else begin
              state        <= ST_SHIFT;
              USR_Mode_Out <= shift_mode(lsb_first);
            end
          end
          ST_SHIFT: begin
            state                <= ST_HOLD;
            bit_cnt              <= bit_cnt + IDX_W'(1);
            USR_Mode_Out         <= NO_CHANGE;
            Serial_Bit_Valid_Out <= 1'b1;
            Bit_Index_Out        <= present_index(lsb_first, bit_cnt + IDX_W'(1));
          end
          ST_GAP: begin
            USR_Mode_Out <= NO_CHANGE;
            if (gap_cnt == 4'd0) begin
              state        <= ST_IDLE;
              Tx_Ready_Out <= 1'b1;
              Busy_Out     <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
          default: begin
            state        <= ST_IDLE;
            USR_Mode_Out <= NO_CHANGE;
            Tx_Ready_Out <= 1'b1;
            Busy_Out     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/usr_shift_sequencer.md
Name: usr_shift_sequencer

Overview:
- Control stage directly upstream of the 8-bit universal shift register (USR).
- Accepts bytes over a valid/ready handshake and drives the USR mode and parallel-load inputs: one LOAD, then alternating HOLD/SHIFT.
- Each data bit is stable on the USR serial output for one full rising-edge-to-rising-edge window.
- Flags that window with a strobe for the serial consumer and pulses on frame completion.

Parameters:
- DATA_WIDTH, 8, byte width; must match the USR width.
- IDLE_GAP, 1, NO_CHANGE cycles inserted after each frame before the next accept (0..15).

Ports:
- Clk_In  input  1  clock; this block uses the rising edge, the USR samples its inputs on the falling edge of the same clock.
- Reset_In  input  1  asynchronous, active-high reset.
- Tx_Data_In  input  8  byte to serialize.
- Tx_Valid_In  input  1  Tx_Data_In valid.
- Tx_Lsb_First_In  input  1  direction: 1 = LSB first, 0 = MSB first; sampled at accept.
- Tx_Ready_Out  output  1  block can accept a byte.
- Abort_In  input  1  synchronous abort of the current frame.
- USR_Mode_Out  output  2  drives USR mode: 0 LOAD_PARALLEL, 1 SHIFT_RIGHT, 2 SHIFT_LEFT, 3 NO_CHANGE.
- USR_Parallel_Data_Out  output  8  drives USR parallel load data.
- Serial_Bit_Valid_Out  output  1  the USR serial output selected by the latched direction holds a valid data bit for this whole cycle.
- Bit_Index_Out  output  3  original data-bit index currently presented.
- Busy_Out  output  1  a frame is in progress (not IDLE).
- Frame_Done_Out  output  1  one-cycle pulse at frame completion.

Behaviour:
- All outputs are registered. The clock is Clk_In and the reset is Reset_In; Reset_In is asynchronous and active-high.
- Reset values:
  - USR_Mode_Out = 3, USR_Parallel_Data_Out = 0.
  - Tx_Ready_Out = 1, Serial_Bit_Valid_Out = 0, Bit_Index_Out = 0.
  - Busy_Out = 0, Frame_Done_Out = 0.
  - State = IDLE, bit counter = 0, gap counter = 0.
- States: IDLE, LOAD, HOLD, SHIFT, GAP.
- IDLE:
  - Mode 3, Tx_Ready_Out = 1.
  - Accept on a rising edge with Tx_Valid_In & Tx_Ready_Out: latch data and direction, clear the bit counter, go to LOAD.
- LOAD (1 cycle):
  - Mode 0 and parallel out = latched data; the USR loads at this cycle's falling edge. Next state HOLD.
- HOLD (1 cycle):
  - Mode 3, Serial_Bit_Valid_Out = 1.
  - Bit_Index_Out = k for LSB first, or 7-k for MSB first, where k is the bit counter.
  - If k = 7, go to GAP when IDLE_GAP > 0, otherwise go to IDLE. Else go to SHIFT.
- SHIFT (1 cycle):
  - Mode 1 for LSB first (consumer reads USR bit 0), mode 2 for MSB first (consumer reads USR bit 7).
  - Serial_Bit_Valid_Out = 0. Increment k. Next state HOLD.
- GAP:
  - Mode 3 for IDLE_GAP cycles, then IDLE.
- Frame timing, counting the accept edge as the start of cycle 1:
  - Cycle 1 is LOAD.
  - HOLD k occupies cycle 2+2k; SHIFT cycles are 3, 5, …, 15.
  - HOLD 7 is cycle 16.
  - Frame_Done_Out = 1 in cycle 17 only.
  - Tx_Ready_Out returns to 1 at cycle 17 + IDLE_GAP.
- Tx_Ready_Out is 1 only in IDLE, so there is no back-to-back accept. Tx_Valid_In outside IDLE is ignored; the data is held by the upstream source.
- Abort_In takes priority over every transition:
  - From LOAD, HOLD, SHIFT or GAP, the next cycle is IDLE with mode 3, no Frame_Done_Out, and the counters cleared.
  - In IDLE, abort blocks the accept in that cycle.
- Asserting Reset_In mid-frame forces the reset values immediately; the USR register content is left to the USR's own reset.
- USR_Parallel_Data_Out holds the latched byte from LOAD until the next accept; it is 0 only after reset.
- The bit counter is 3 bits and never wraps within a frame; the k = 7 check precedes the increment.

Decomposition:
- Shared package usr_pkg:
  - USR mode constants LOAD_PARALLEL = 2'h0, SHIFT_RIGHT = 2'h1, SHIFT_LEFT = 2'h2, NO_CHANGE = 2'h3, reused by the USR and this block.
  - Sequencer state encoding.
- Single module; no sub-module. The state register, bit counter and gap counter are local.

Test Plan:
- Reset then idle: Reset_In pulse, Tx_Valid_In = 0 for 10 cycles → mode 3, ready 1, busy 0, done 0 throughout.
- LSB first: accept 8'hA5 with Tx_Lsb_First_In = 1, IDLE_GAP = 1, USR connected.
  - Mode sequence is 0, then 3 and 1 alternating, with seven 1s.
  - USR bit 0 sampled while valid reads 1,0,1,0,0,1,0,1 with Bit_Index_Out 0..7.
  - Done in cycle 17; ready returns in cycle 18.
- MSB first: accept 8'h3C with Tx_Lsb_First_In = 0 → mode 2 in SHIFT cycles; USR bit 7 reads 0,0,1,1,1,1,0,0 with Bit_Index_Out 7..0.
- IDLE_GAP = 0 with Tx_Valid_In held high, 8'h01 then 8'h80 → second accept on the cycle-17 edge (ready and done both 1 in cycle 17); the second frame's LOAD is in cycle 18.
- Abort: Abort_In asserted during HOLD 3 → next cycle IDLE with mode 3; no Frame_Done_Out; the next byte 8'hFF serializes correctly.
- Mid-frame reset: Reset_In asserted between edges in cycle 9 → outputs take reset values without waiting for an edge; the following 8'h5A frame is correct.
